// File: rtl/ptw_mem_responder.sv
// Page-table-walk memory responder: one PTE read at a time over a req/gnt/rvalid port,
// with a one-entry last-PTE buffer, alignment check and a saturating timeout.
module ptw_mem_responder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ptw_req,
  input  logic [ADDR_WIDTH-1:0] ptw_addr,
  output logic [DATA_WIDTH-1:0] ptw_data,
  output logic                  ptw_ready,
  output logic                  ptw_err,
  output logic                  busy,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_err
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  flush_seen_q, flush_seen_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic misaligned;
  logic hit;
  logic timeout;
  logic fill;

  assign misaligned = (ptw_addr[1:0] != 2'b00);
  // A flush in the request cycle must not be answered from the stale buffer.
  assign hit        = buf_valid_q && (buf_addr_q == ptw_addr) && !flush;
  assign timeout    = (cnt_q == CntMax);
  assign fill       = (state_q == StResp) && mem_rvalid && !mem_err && !flush_seen_q && !flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ptw_req) begin
          state_d = (misaligned || hit) ? StDone : StReq;
        end
      end
      StReq: begin
        if (timeout) begin
          state_d = StDone;
        end else if (mem_gnt) begin
          state_d = StResp;
        end
      end
      StResp: begin
        // Completion takes priority over a coincident timeout.
        if (mem_rvalid || timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ptw_ready = (state_q == StDone);
    ptw_err   = (state_q == StDone) && err_q;
    ptw_data  = data_q;
    busy      = (state_q != StIdle);
    mem_req   = (state_q == StReq);
    mem_addr  = addr_q;
  end

  // Transaction datapath: address, timeout counter, response registers
  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    flush_seen_d = flush_seen_q;
    data_d       = data_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (ptw_req) begin
          addr_d       = ptw_addr;
          cnt_d        = '0;
          flush_seen_d = 1'b0;
          if (misaligned) begin
            data_d = '0;
            err_d  = 1'b1;
          end else if (hit) begin
            data_d = buf_data_q;
            err_d  = 1'b0;
          end
        end
      end
      StReq: begin
        cnt_d        = timeout ? cnt_q : cnt_q + CntWidth'(1);
        flush_seen_d = flush_seen_q | flush;
        if (timeout) begin
          data_d = '0;
          err_d  = 1'b1;
        end
      end
      StResp: begin
        cnt_d        = timeout ? cnt_q : cnt_q + CntWidth'(1);
        flush_seen_d = flush_seen_q | flush;
        if (mem_rvalid) begin
          data_d = mem_rdata;
          err_d  = mem_err;
        end else if (timeout) begin
          data_d = '0;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Last-PTE buffer; flush clears it in any state
  always_comb begin
    buf_valid_d = flush ? 1'b0 : buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (fill) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = addr_q;
      buf_data_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      flush_seen_q <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      flush_seen_q <= flush_seen_d;
      data_q       <= data_d;
      err_q        <= err_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Directed bench for ptw_mem_responder with TIMEOUT_CYCLES=8; inputs driven and outputs
// sampled on the falling edge.
module tb_ptw_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ptw_req = 1'b0;
  logic [31:0] ptw_addr = '0;
  logic [31:0] ptw_data;
  logic        ptw_ready;
  logic        ptw_err;
  logic        busy;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  ptw_mem_responder #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ptw_req   (ptw_req),
    .ptw_addr  (ptw_addr),
    .ptw_data  (ptw_data),
    .ptw_ready (ptw_ready),
    .ptw_err   (ptw_err),
    .busy      (busy),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  // Issues one request and plays memory. gnt_wait<0 never grants. lat is the number of
  // cycles from the request cycle to ptw_ready (-1 if none within the budget).
  task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata, input bit rerr,
                         input int gnt_wait, input int rv_wait, input int flush_at,
                         output int lat, output logic [31:0] data, output logic perr,
                         output int req_cycles, output bit stable);
    bit granted = 1'b0;
    int resp_n = 0;
    lat = -1; data = '0; perr = 1'b0; req_cycles = 0; stable = 1'b1;
    @(negedge clk);
    ptw_req = 1'b1; ptw_addr = addr; flush = (flush_at == 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ptw_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
      flush = (c == flush_at);
      if (ptw_ready) begin
        lat = c; data = ptw_data; perr = ptw_err;
        break;
      end else if (mem_req && !granted) begin
        req_cycles++;
        if (mem_addr !== addr) stable = 1'b0;
        if (gnt_wait >= 0 && req_cycles > gnt_wait) begin
          mem_gnt = 1'b1; granted = 1'b1;
        end
      end else if (granted) begin
        resp_n++;
        if (resp_n > rv_wait) begin
          mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = rerr;
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++; if (ptw_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", ptw_ready); end
    vectors++; if (ptw_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", ptw_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    vectors++; if (ptw_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h exp 0", ptw_data); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_miss_then_hit();
    int lat, rc; logic [31:0] d; logic e; bit st;
    do_read(32'h0000_1004, 32'h2000_0C01, 1'b0, 0, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL miss_latency got %0d exp 3", lat); end
    vectors++; if (d !== 32'h2000_0C01) begin miscompares++; $display("FAIL miss_data got %h exp 20000c01", d); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL miss_err got %b exp 0", e); end
    vectors++; if (rc !== 1) begin miscompares++; $display("FAIL miss_req_cycles got %0d exp 1", rc); end
    @(negedge clk);
    vectors++; if (ptw_ready !== 1'b0) begin miscompares++; $display("FAIL ready_one_cycle got %b exp 0", ptw_ready); end
    vectors++; if (ptw_data !== 32'h2000_0C01) begin miscompares++; $display("FAIL data_hold got %h exp 20000c01", ptw_data); end
    do_read(32'h0000_1004, 32'hFFFF_FFFF, 1'b0, 0, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL hit_latency got %0d exp 1", lat); end
    vectors++; if (d !== 32'h2000_0C01) begin miscompares++; $display("FAIL hit_data got %h exp 20000c01", d); end
    vectors++; if (rc !== 0) begin miscompares++; $display("FAIL hit_no_mem_req got %0d exp 0", rc); end
  endtask

  task automatic test_misaligned();
    int lat, rc; logic [31:0] d; logic e; bit st;
    do_read(32'h0000_1002, 32'h1234_5678, 1'b0, 0, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL misal_latency got %0d exp 1", lat); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL misal_err got %b exp 1", e); end
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL misal_data got %h exp 0", d); end
    vectors++; if (rc !== 0) begin miscompares++; $display("FAIL misal_no_mem_req got %0d exp 0", rc); end
  endtask

  task automatic test_stall_error();
    int lat, rc; logic [31:0] d; logic e; bit st;
    do_read(32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 3, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL stall_latency got %0d exp 6", lat); end
    vectors++; if (rc !== 4) begin miscompares++; $display("FAIL stall_req_cycles got %0d exp 4", rc); end
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL stall_addr_stable got %b exp 1", st); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL bus_err got %b exp 1", e); end
    do_read(32'h0000_3000, 32'h1111_2222, 1'b0, 0, 2, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL err_no_fill_latency got %0d exp 5", lat); end
    vectors++; if (rc !== 1) begin miscompares++; $display("FAIL err_no_fill_req got %0d exp 1", rc); end
    vectors++; if (d !== 32'h1111_2222 || e !== 1'b0) begin miscompares++; $display("FAIL rv_stall_resp got %h/%b exp 11112222/0", d, e); end
    @(negedge clk);
    vectors++; if (ptw_err !== 1'b0) begin miscompares++; $display("FAIL err_outside_done got %b exp 0", ptw_err); end
  endtask

  task automatic test_timeout();
    int lat, rc; logic [31:0] d; logic e; bit st;
    do_read(32'h0000_4000, 32'hAAAA_5555, 1'b0, -1, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL timeout_latency got %0d exp 10", lat); end
    vectors++; if (e !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL timeout_resp got %h/%b exp 0/1", d, e); end
    vectors++; if (rc !== 9) begin miscompares++; $display("FAIL timeout_req_cycles got %0d exp 9", rc); end
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ptw_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL stray_rvalid got ready=%b busy=%b exp 0/0", ptw_ready, busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_races();
    int lat, rc; logic [31:0] d; logic e; bit st;
    do_read(32'h0000_2000, 32'h0000_2C01, 1'b0, 0, 1, 2, lat, d, e, rc, st);
    vectors++; if (lat !== 4 || d !== 32'h0000_2C01) begin miscompares++; $display("FAIL flush_resp got lat=%0d data=%h exp 4/00002c01", lat, d); end
    do_read(32'h0000_2000, 32'h0000_2C02, 1'b0, 0, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 3 || rc !== 1) begin miscompares++; $display("FAIL flush_no_fill got lat=%0d req=%0d exp 3/1", lat, rc); end
    do_read(32'h0000_2000, 32'h0000_2C03, 1'b0, 0, 0, 0, lat, d, e, rc, st);
    vectors++; if (lat !== 3 || rc !== 1 || d !== 32'h0000_2C03) begin miscompares++; $display("FAIL flush_forces_miss got lat=%0d req=%0d data=%h exp 3/1/00002c03", lat, rc, d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ptw_req = 1'b1; ptw_addr = 32'h0000_1002;
    @(negedge clk);
    vectors++; if (ptw_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_first got %b exp 1", ptw_ready); end
    ptw_addr = 32'h0000_1006;
    @(negedge clk);
    vectors++; if (ptw_ready !== 1'b0) begin miscompares++; $display("FAIL req_in_done_ignored got %b exp 0", ptw_ready); end
    @(negedge clk);
    ptw_req = 1'b0;
    vectors++; if (ptw_ready !== 1'b1 || ptw_err !== 1'b1) begin miscompares++; $display("FAIL b2b_second got %b/%b exp 1/1", ptw_ready, ptw_err); end
  endtask

  task automatic test_reset_mid_req();
    int lat, rc; logic [31:0] d; logic e; bit st;
    @(negedge clk);
    ptw_req = 1'b1; ptw_addr = 32'h0000_5000;
    @(negedge clk);
    ptw_req = 1'b0;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL pre_reset_mem_req got %b exp 1", mem_req); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL async_abort got req=%b busy=%b exp 0/0", mem_req, busy); end
    @(negedge clk);
    vectors++; if (ptw_ready !== 1'b0) begin miscompares++; $display("FAIL reset_no_ready got %b exp 0", ptw_ready); end
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_0001;
    @(negedge clk);
    mem_rvalid = 1'b0;
    vectors++; if (ptw_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_stray got %b/%b exp 0/0", ptw_ready, busy); end
    do_read(32'h0000_2000, 32'h0000_2C04, 1'b0, 0, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 3 || rc !== 1) begin miscompares++; $display("FAIL reset_clears_buffer got lat=%0d req=%0d exp 3/1", lat, rc); end
    do_read(32'h0000_5000, 32'h0000_5C01, 1'b0, 0, 0, -1, lat, d, e, rc, st);
    vectors++; if (lat !== 3 || d !== 32'h0000_5C01 || e !== 1'b0) begin miscompares++; $display("FAIL post_reset_read got lat=%0d data=%h err=%b exp 3/00005c01/0", lat, d, e); end
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_misaligned();
    test_stall_error();
    test_timeout();
    test_flush_races();
    test_back_to_back();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
